// File: rtl/feeder_pkg.sv
// Shared types and width helpers for the skewed systolic-array operand feeder.
package feeder_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, GAP, DRAIN} state_t;

  localparam int DEF_DATA_SIZE = 32;
  typedef logic [DEF_DATA_SIZE-1:0] word_t;

  // Word address into the MxM operand store (at least one bit).
  function automatic int addr_w(input int m);
    return (m * m > 1) ? $clog2(m * m) : 1;
  endfunction

  // Fetch pointer reaches M*M after the last group, so it needs one extra code.
  function automatic int ptr_w(input int m);
    return $clog2(m * m + 1);
  endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Stallable data+valid delay line; DEPTH=0 is a straight wire.
module skew_delay_line #(
  parameter int DEPTH     = 1,
  parameter int DATA_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 in_valid,
  input  logic [DATA_SIZE-1:0] in_data,
  output logic                 out_valid,
  output logic [DATA_SIZE-1:0] out_data
);

  generate
    if (DEPTH == 0) begin : g_wire
      assign out_valid = in_valid;
      assign out_data  = in_data;
    end else begin : g_pipe
      logic [DEPTH-1:0]                vld_pipe;
      logic [DEPTH-1:0][DATA_SIZE-1:0] dat_pipe;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          vld_pipe <= '0;
          dat_pipe <= '0;
        end else if (enable) begin
          vld_pipe[0] <= in_valid;
          dat_pipe[0] <= in_data;
          for (int s = 1; s < DEPTH; s++) begin
            vld_pipe[s] <= vld_pipe[s-1];
            dat_pipe[s] <= dat_pipe[s-1];
          end
        end
      end

      assign out_valid = vld_pipe[DEPTH-1];
      assign out_data  = dat_pipe[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/skewed_data_feeder.sv
// Streams an MxM operand matrix into a systolic array edge, one row group per
// fetch at a programmable interval, with lane i skewed by i cycles.
module skewed_data_feeder
  import feeder_pkg::*;
#(
  parameter int MATRIX_SIZE = 2,
  parameter int DATA_SIZE   = DEF_DATA_SIZE,
  parameter int INTERVAL_W  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          wr_en,
  input  logic [addr_w(MATRIX_SIZE)-1:0] wr_addr,
  input  logic [DATA_SIZE-1:0]          wr_data,
  input  logic                          start,
  input  logic [INTERVAL_W-1:0]         interval,
  output logic                          busy,
  output logic                          done,
  output logic [MATRIX_SIZE-1:0]        data_valid_out,
  output logic [DATA_SIZE-1:0]          data_out [MATRIX_SIZE-1:0]
);

  localparam int WORDS = MATRIX_SIZE * MATRIX_SIZE;
  localparam int AW    = addr_w(MATRIX_SIZE);
  localparam int PW    = ptr_w(MATRIX_SIZE);
  localparam int DW    = $clog2(MATRIX_SIZE) + 1;
  // One counter serves both the inter-fetch gap and the drain count.
  localparam int CW    = (INTERVAL_W > DW) ? INTERVAL_W : DW;
  localparam int LAST  = WORDS - MATRIX_SIZE;

  state_t                state, state_n;
  logic [PW-1:0]         ptr, ptr_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic [INTERVAL_W-1:0] ivl, ivl_n;
  logic                  done_n;
  logic                  issue;

  logic [DATA_SIZE-1:0]  dmem [WORDS];

  always_ff @(posedge clk) begin
    if (wr_en && enable && state == IDLE)
      dmem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= '0;
      cnt   <= '0;
      ivl   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      cnt   <= cnt_n;
      ivl   <= ivl_n;
      done  <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    cnt_n   = cnt;
    ivl_n   = ivl;
    done_n  = 1'b0;
    issue   = 1'b0;
    if (enable) begin
      case (state)
        IDLE: begin
          if (start) begin
            state_n = ISSUE;
            ivl_n   = interval;
            ptr_n   = '0;
          end
        end
        ISSUE: begin
          issue = 1'b1;
          ptr_n = ptr + PW'(MATRIX_SIZE);
          if (ptr == PW'(LAST)) begin
            state_n = DRAIN;
            cnt_n   = CW'(MATRIX_SIZE - 1);
          end else if (ivl != '0) begin
            state_n = GAP;
            cnt_n   = CW'(ivl) - CW'(1);
          end
        end
        GAP: begin
          if (cnt == '0) state_n = ISSUE;
          else           cnt_n   = cnt - CW'(1);
        end
        DRAIN: begin
          if (cnt == '0) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            cnt_n = cnt - CW'(1);
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

  generate
    for (genvar i = 0; i < MATRIX_SIZE; i++) begin : g_lane
      logic [AW-1:0]        addr;
      logic                 s0_vld;
      logic [DATA_SIZE-1:0] s0_data;
      logic                 lane_vld;
      logic [DATA_SIZE-1:0] lane_data;

      assign addr = AW'(ptr + PW'(i));

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          s0_vld  <= 1'b0;
          s0_data <= '0;
        end else if (enable) begin
          s0_vld  <= issue;
          s0_data <= issue ? dmem[addr] : '0;
        end
      end

      skew_delay_line #(.DEPTH(i), .DATA_SIZE(DATA_SIZE)) u_skew (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .in_valid (s0_vld),
        .in_data  (s0_data),
        .out_valid(lane_vld),
        .out_data (lane_data)
      );

      // Stages hold during a stall, but nothing is presented downstream.
      assign data_valid_out[i] = enable & lane_vld;
      assign data_out[i]       = (enable && lane_vld) ? lane_data : '0;
    end
  endgenerate

endmodule

// File: tb/tb_skewed_data_feeder.sv
// Directed bench: 2x2 feeder through timing/stall/ignore/reset cases, 4x4 skew pattern.
module tb_skewed_data_feeder;

  logic        clk = 1'b0;
  logic        reset;

  logic        a_enable, a_wr_en, a_start;
  logic [1:0]  a_wr_addr;
  logic [31:0] a_wr_data;
  logic [3:0]  a_interval;
  logic        a_busy, a_done;
  logic [1:0]  a_v;
  logic [31:0] a_dout [1:0];

  logic        b_enable, b_wr_en, b_start;
  logic [3:0]  b_wr_addr;
  logic [31:0] b_wr_data;
  logic [3:0]  b_interval;
  logic        b_busy, b_done;
  logic [3:0]  b_v;
  logic [31:0] b_dout [3:0];

  int          tests  = 0;
  int          failed = 0;
  logic        ev;
  logic [31:0] ed;

  always #5 clk = ~clk;

  skewed_data_feeder #(.MATRIX_SIZE(2), .DATA_SIZE(32), .INTERVAL_W(4)) u_a (
    .clk(clk), .reset(reset), .enable(a_enable), .wr_en(a_wr_en),
    .wr_addr(a_wr_addr), .wr_data(a_wr_data), .start(a_start),
    .interval(a_interval), .busy(a_busy), .done(a_done),
    .data_valid_out(a_v), .data_out(a_dout)
  );

  skewed_data_feeder #(.MATRIX_SIZE(4), .DATA_SIZE(32), .INTERVAL_W(4)) u_b (
    .clk(clk), .reset(reset), .enable(b_enable), .wr_en(b_wr_en),
    .wr_addr(b_wr_addr), .wr_data(b_wr_data), .start(b_start),
    .interval(b_interval), .busy(b_busy), .done(b_done),
    .data_valid_out(b_v), .data_out(b_dout)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {busy, done, valid[1:0], lane1, lane0} of the 2x2 instance
  task automatic chk2(input string tag, input logic b, input logic dn,
                      input logic [1:0] v, input logic [31:0] d1, input logic [31:0] d0);
    chk(tag, {a_busy, a_done, a_v, a_dout[1], a_dout[0]}, {b, dn, v, d1, d0});
  endtask

  task automatic a_write(input logic [1:0] addr, input logic [31:0] data);
    a_wr_en = 1'b1; a_wr_addr = addr; a_wr_data = data;
    step();
    a_wr_en = 1'b0;
  endtask

  task automatic a_go(input logic [3:0] ivl);
    a_start = 1'b1; a_interval = ivl;
    step();
    a_start = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    a_enable = 1'b1; a_wr_en = 1'b0; a_start = 1'b0; a_wr_addr = '0; a_wr_data = '0; a_interval = '0;
    b_enable = 1'b1; b_wr_en = 1'b0; b_start = 1'b0; b_wr_addr = '0; b_wr_data = '0; b_interval = '0;
    step();
    step();
    chk2("reset_state", 0, 0, 2'b00, 0, 0);
    reset = 1'b0;
    step();

    a_write(2'd0, 32'd1); a_write(2'd1, 32'd3); a_write(2'd2, 32'd2); a_write(2'd3, 32'd4);

    // interval 0
    a_go(4'd0);
    chk2("i0_e0", 1, 0, 2'b00, 0, 0);
    step(); chk2("i0_e1", 1, 0, 2'b01, 0, 1);
    step(); chk2("i0_e2", 1, 0, 2'b11, 3, 2);
    step(); chk2("i0_e3", 1, 0, 2'b10, 4, 0);
    step(); chk2("i0_e4_done", 0, 1, 2'b00, 0, 0);
    step(); chk2("i0_e5_idle", 0, 0, 2'b00, 0, 0);

    // interval 3
    a_go(4'd3);
    chk2("i3_e0", 1, 0, 2'b00, 0, 0);
    step(); chk2("i3_e1", 1, 0, 2'b01, 0, 1);
    step(); chk2("i3_e2", 1, 0, 2'b10, 3, 0);
    step(); chk2("i3_e3_gap", 1, 0, 2'b00, 0, 0);
    step(); chk2("i3_e4_gap", 1, 0, 2'b00, 0, 0);
    step(); chk2("i3_e5", 1, 0, 2'b01, 0, 2);
    step(); chk2("i3_e6", 1, 0, 2'b10, 4, 0);
    step(); chk2("i3_e7_done", 0, 1, 2'b00, 0, 0);
    step(); chk2("i3_e8_idle", 0, 0, 2'b00, 0, 0);

    // two-cycle stall after E2
    a_go(4'd0);
    step(); chk2("st_e1", 1, 0, 2'b01, 0, 1);
    step(); chk2("st_e2", 1, 0, 2'b11, 3, 2);
    a_enable = 1'b0;
    step(); chk2("st_stall1", 1, 0, 2'b00, 0, 0);
    step(); chk2("st_stall2", 1, 0, 2'b00, 0, 0);
    a_enable = 1'b1;
    #1; chk2("st_resume", 1, 0, 2'b11, 3, 2);
    step(); chk2("st_e5", 1, 0, 2'b10, 4, 0);
    step(); chk2("st_e6_done", 0, 1, 2'b00, 0, 0);
    step(); chk2("st_e7_idle", 0, 0, 2'b00, 0, 0);

    // start and write while busy are ignored
    a_go(4'd0);
    step(); chk2("ig_e1", 1, 0, 2'b01, 0, 1);
    a_start = 1'b1; a_wr_en = 1'b1; a_wr_addr = 2'd3; a_wr_data = 32'd99;
    step(); chk2("ig_e2", 1, 0, 2'b11, 3, 2);
    a_start = 1'b0; a_wr_en = 1'b0;
    step(); chk2("ig_e3", 1, 0, 2'b10, 4, 0);
    step(); chk2("ig_e4_done", 0, 1, 2'b00, 0, 0);
    step(); chk2("ig_e5_once", 0, 0, 2'b00, 0, 0);
    step(); chk2("ig_e6_once", 0, 0, 2'b00, 0, 0);

    // asynchronous reset mid-stream, then replay
    a_go(4'd0);
    step();
    step(); chk2("rs_e2", 1, 0, 2'b11, 3, 2);
    #2 reset = 1'b1;
    #1 chk2("rs_async", 0, 0, 2'b00, 0, 0);
    #2 reset = 1'b0;
    step(); chk2("rs_nodone1", 0, 0, 2'b00, 0, 0);
    step(); chk2("rs_nodone2", 0, 0, 2'b00, 0, 0);
    a_go(4'd0);
    step(); chk2("rp_e1", 1, 0, 2'b01, 0, 1);
    step(); chk2("rp_e2", 1, 0, 2'b11, 3, 2);
    step(); chk2("rp_e3", 1, 0, 2'b10, 4, 0);
    step(); chk2("rp_e4_done", 0, 1, 2'b00, 0, 0);

    // write in the start cycle is seen by the first fetch
    a_wr_en = 1'b1; a_wr_addr = 2'd0; a_wr_data = 32'd5;
    a_go(4'd0);
    a_wr_en = 1'b0;
    step(); chk2("ws_e1", 1, 0, 2'b01, 0, 5);
    step(); chk2("ws_e2", 1, 0, 2'b11, 3, 2);
    step();
    step(); chk2("ws_e4_done", 0, 1, 2'b00, 0, 0);

    // 4x4, words 0..15, interval 1: fetch k at E(1+2k), lane i shows 4k+i after E(1+2k+i)
    for (int w = 0; w < 16; w++) begin
      b_wr_en = 1'b1; b_wr_addr = 4'(w); b_wr_data = 32'(w);
      step();
    end
    b_wr_en = 1'b0;
    b_start = 1'b1; b_interval = 4'd1;
    step();
    b_start = 1'b0;
    chk("m4_e0_busy", {b_busy, b_done, b_v}, {1'b1, 1'b0, 4'b0000});
    for (int e = 1; e <= 12; e++) begin
      step();
      for (int i = 0; i < 4; i++) begin
        ev = 1'b0; ed = '0;
        for (int k = 0; k < 4; k++)
          if (e == 1 + 2 * k + i) begin ev = 1'b1; ed = 32'(4 * k + i); end
        chk($sformatf("m4_e%0d_lane%0d", e, i), {b_v[i], b_dout[i]}, {ev, ed});
      end
      chk($sformatf("m4_e%0d_ctl", e), {b_busy, b_done}, {(e < 11), (e == 11)});
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
